// File: rtl/launcher_pkg.sv
// rtl/launcher_pkg.sv - shared types and default constants for the program launcher
//
// Purpose: state encoding and parameter defaults used by prog_launcher and its
// counter sub-module.
package launcher_pkg;

  localparam int DEF_CNT_W   = 16;    // run-cycle counter width
  localparam int DEF_RST_CYC = 4;     // cycles cpu_reset is held per launch
  localparam int DEF_TIMEOUT = 1000;  // run-cycle abort limit (timeout build only)

  // Hold counter is sized for the largest legal RST_CYC (255).
  localparam int HOLD_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_RST,
    REQ,
    RUN,
    FIN
  } state_e;

endpackage

// File: rtl/launch_cycle_ctr.sv
// rtl/launch_cycle_ctr.sv - clear/enable counter that saturates at all-ones
//
// Purpose: shared counter for the cpu_reset hold interval and the run-cycle count.
// Ports:
//   clk_i    rising-edge clock
//   reset_i  synchronous active-high reset, clears the count
//   clr_i    synchronous clear (takes priority over en_i)
//   en_i     increment by one, holding at all-ones
//   count_o  current count
module launch_cycle_ctr #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prog_launcher.sv
// rtl/prog_launcher.sv - launches a CPU run: reset hold, run request, cycle count
//
// Purpose: on a rising edge of start, holds cpu_reset for RST_CYC cycles, pulses
// cpu_req for one cycle, then counts run cycles until the registered cpu_done.
// Optional macro PROG_LAUNCHER_TIMEOUT_EN aborts the run after TIMEOUT cycles.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (also forces cpu_reset high)
//   start      host launch request, rising edge launches
//   cpu_done   done flag from the CPU, registered before use
//   cpu_reset  reset to the CPU
//   cpu_req    one-cycle run request to the CPU
//   busy       launch in progress
//   finished   run complete, result valid
//   timed_out  run aborted by timeout
//   cycles     run-cycle count of the last run
module prog_launcher
  import launcher_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int RST_CYC = DEF_RST_CYC,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cpu_done,
  output logic             cpu_reset,
  output logic             cpu_req,
  output logic             busy,
  output logic             finished,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycles
);

  state_e              state_q, state_d;
  logic                start_q;
  logic                armed_q;
  logic                done_q;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                launch;
  logic                hold_last;
  logic                run_en;

  // armed_q blocks a launch from a start level that was already high across
  // reset; it is set once start has been seen low.
  assign launch    = (state_q == IDLE) && start && !start_q && armed_q;
  assign hold_last = (hold_cnt == HOLD_W'(RST_CYC - 1));
  assign run_en    = (state_q == RUN) && !done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      armed_q <= !start;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      armed_q <= armed_q || !start;
      // Only samples taken during RUN count, so a stale done from the previous
      // program cannot end the new run early.
      done_q  <= cpu_done && (state_q == RUN);
    end
  end

  launch_cycle_ctr #(.W(HOLD_W)) u_hold_ctr (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (launch),
    .en_i    (state_q == HOLD_RST),
    .count_o (hold_cnt)
  );

  launch_cycle_ctr #(.W(CNT_W)) u_run_ctr (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (launch),
    .en_i    (run_en),
    .count_o (cycles)
  );

`ifdef PROG_LAUNCHER_TIMEOUT_EN
  logic timeout_hit;
  logic timed_out_q;

  // The counting edge that brings cycles to TIMEOUT also ends the run; a done
  // on that edge takes priority because run_en is then low.
  assign timeout_hit = run_en && (cycles == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      timed_out_q <= 1'b0;
    end else if (launch) begin
      timed_out_q <= 1'b0;
    end else if (timeout_hit) begin
      timed_out_q <= 1'b1;
    end
  end

  assign timed_out = timed_out_q;
`else
  // No timeout in this build; TIMEOUT has no effect.
  assign timed_out = 1'b0 & (TIMEOUT == 0);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (launch) state_d = HOLD_RST;
      HOLD_RST: if (hold_last) state_d = REQ;
      REQ:      state_d = RUN;
      RUN: begin
        if (done_q) begin
          state_d = FIN;
        end
`ifdef PROG_LAUNCHER_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = FIN;
        end
`endif
      end
      FIN:      if (!start) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_reset = reset || (state_q == HOLD_RST);
    cpu_req   = (state_q == REQ);
    busy      = (state_q == HOLD_RST) || (state_q == REQ) || (state_q == RUN);
    finished  = (state_q == FIN);
  end

endmodule

// File: tb/tb_prog_launcher.sv
// tb/tb_prog_launcher.sv - scoreboard bench for prog_launcher
module tb_prog_launcher;

  localparam int CNT_W   = 4;
  localparam int RST_CYC = 4;
  localparam int TIMEOUT = 12;

`ifdef PROG_LAUNCHER_TIMEOUT_EN
  localparam int SAT_CYC = TIMEOUT;
  localparam int SAT_TO  = 1;
`else
  localparam int SAT_CYC = 15;
  localparam int SAT_TO  = 0;
`endif

  localparam int EV_RST = 0;
  localparam int EV_REQ = 1;
  localparam int EV_FIN = 2;

  typedef struct {
    int kind;
    int data;
  } ev_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic             cpu_done;
  logic             cpu_reset;
  logic             cpu_req;
  logic             busy;
  logic             finished;
  logic             timed_out;
  logic [CNT_W-1:0] cycles;

  ev_t expq[$];
  int  tests;
  int  fails;
  int  req_pulses;

  prog_launcher #(
    .CNT_W   (CNT_W),
    .RST_CYC (RST_CYC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cpu_done  (cpu_done),
    .cpu_reset (cpu_reset),
    .cpu_req   (cpu_req),
    .busy      (busy),
    .finished  (finished),
    .timed_out (timed_out),
    .cycles    (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    expq.push_back(e);
  endtask

  task automatic observe(input int kind, input int data);
    ev_t e;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d data %0d expected none", kind, data);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.data != data) begin
        fails++;
        $display("FAIL event: got kind %0d data %0d expected kind %0d data %0d",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    int  rst_run;
    int  req_run;
    logic fin_prev;
    rst_run  = 0;
    req_run  = 0;
    fin_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        rst_run  = 0;
        req_run  = 0;
        fin_prev = 1'b0;
      end else begin
        if (cpu_reset) begin
          rst_run++;
        end else if (rst_run > 0) begin
          observe(EV_RST, rst_run);
          rst_run = 0;
        end
        if (cpu_req) begin
          req_run++;
        end else if (req_run > 0) begin
          req_pulses++;
          observe(EV_REQ, req_run);
          req_run = 0;
        end
        if (finished && !fin_prev) begin
          observe(EV_FIN, int'(timed_out) * 256 + int'(cycles));
          check("busy_with_finished", int'(busy), 0);
        end
        fin_prev = finished;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!cpu_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_cpu_req", int'(cpu_req), 1);
  endtask

  task automatic wait_fin();
    int n;
    n = 0;
    while (!finished && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_finished", int'(finished), 1);
  endtask

  task automatic expect_launch(input int fin_data, input bit with_fin);
    expect_ev(EV_RST, RST_CYC);
    expect_ev(EV_REQ, 1);
    if (with_fin) expect_ev(EV_FIN, fin_data);
  endtask

  initial begin
    int snap;
    tests      = 0;
    fails      = 0;
    req_pulses = 0;
    reset      = 1'b1;
    start      = 1'b0;
    cpu_done   = 1'b0;
    tick(2);
    check("rst_cpu_reset", int'(cpu_reset), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_finished", int'(finished), 0);
    check("rst_cpu_req", int'(cpu_req), 0);
    check("rst_cycles", int'(cycles), 0);
    check("rst_timed_out", int'(timed_out), 0);
    reset = 1'b0;
    tick(1);
    check("idle_cpu_reset", int'(cpu_reset), 0);

    // Basic launch: done 10 cycles after cpu_req.
    expect_launch(10, 1'b1);
    start = 1'b1;
    tick(1);
    check("launch_cpu_reset", int'(cpu_reset), 1);
    check("launch_busy", int'(busy), 1);
    wait_req();
    tick(10);
    cpu_done = 1'b1;
    wait_fin();
    cpu_done = 1'b0;
    start    = 1'b0;
    tick(1);
    check("basic_idle_finished", int'(finished), 0);
    check("basic_cycles_kept", int'(cycles), 10);

    // Stale done held high through HOLD_RST/REQ.
    expect_launch(3, 1'b1);
    start    = 1'b1;
    cpu_done = 1'b1;
    wait_req();
    tick(1);
    cpu_done = 1'b0;
    tick(1);
    check("stale_no_early_finish", int'(finished), 0);
    tick(1);
    cpu_done = 1'b1;
    wait_fin();
    cpu_done = 1'b0;

    // Start held high after FIN: no relaunch.
    snap = req_pulses;
    tick(20);
    check("held_finished", int'(finished), 1);
    check("held_no_req", req_pulses, snap);
    start = 1'b0;
    tick(1);
    check("held_release_finished", int'(finished), 0);
    check("held_release_busy", int'(busy), 0);

    // Relaunch clears cycles; long run saturates (or times out).
    expect_launch(SAT_TO * 256 + SAT_CYC, 1'b1);
    start = 1'b1;
    tick(1);
    check("relaunch_cycles_clear", int'(cycles), 0);
    wait_req();
    tick(20);
    cpu_done = 1'b1;
    wait_fin();
    cpu_done = 1'b0;
    start    = 1'b0;
    tick(2);

    // Reset at RUN cycle 5 with start high.
    expect_launch(0, 1'b0);
    start = 1'b1;
    wait_req();
    tick(5);
    reset = 1'b1;
    tick(1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_finished", int'(finished), 0);
    check("midrst_cpu_req", int'(cpu_req), 0);
    check("midrst_cpu_reset", int'(cpu_reset), 1);
    check("midrst_cycles", int'(cycles), 0);
    check("midrst_timed_out", int'(timed_out), 0);
    snap  = req_pulses;
    reset = 1'b0;
    tick(10);
    check("postrst_no_launch_busy", int'(busy), 0);
    check("postrst_cpu_reset", int'(cpu_reset), 0);
    check("postrst_no_req", req_pulses, snap);

    // Toggle start: launch works again.
    start = 1'b0;
    tick(1);
    expect_launch(2, 1'b1);
    start = 1'b1;
    wait_req();
    tick(2);
    cpu_done = 1'b1;
    wait_fin();
    cpu_done = 1'b0;
    start    = 1'b0;
    tick(5);

    check("scoreboard_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
